imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 118 +++++++++++
 tb/tb_imem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency fetch pipeline feeding an in-order
// response FIFO, with a program-load write port and flush/reset discard.
module imem_responder #(
  parameter int N_BITS      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int RESP_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_BITS-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_BITS-1:0] resp_data,
  output logic              resp_err,
  input  logic              flush,
  input  logic              load_en,
  input  logic [N_BITS-1:0] load_addr,
  input  logic [N_BITS-1:0] load_data
);

  localparam logic [N_BITS-1:0] NOP = N_BITS'(32'h0000_0013);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic              err;
    logic [N_BITS-1:0] data;
  } resp_t;

  logic [N_BITS-1:0] mem [DEPTH_WORDS];

  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  resp_t              pipe_q [LATENCY];
  resp_t              fifo_q [RESP_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      out_q, out_d;

  logic              accept, pop, push;
  logic [N_BITS-3:0] req_widx, ld_widx;
  logic              req_in_range, ld_in_range, req_err;
  resp_t             rd_resp, head;
  logic              unused_ok;

  assign unused_ok = ^load_addr[1:0];

  // Request decode and storage read happen at the accept edge.
  assign req_widx     = req_addr[N_BITS-1:2];
  assign req_in_range = {2'b00, req_widx} < N_BITS'(DEPTH_WORDS);
  assign req_err      = (req_addr[1:0] != 2'b00) | ~req_in_range;
  assign rd_resp.err  = req_err;
  assign rd_resp.data = req_err ? NOP : mem[req_addr[AW+1:2]];

  assign ld_widx     = load_addr[N_BITS-1:2];
  assign ld_in_range = {2'b00, ld_widx} < N_BITS'(DEPTH_WORDS);

  // Storage survives reset; a same-edge load/read returns the old word.
  always_ff @(posedge clk) begin
    if (load_en && ld_in_range) mem[load_addr[AW+1:2]] <= load_data;
  end

  assign req_ready  = rst_n & ~flush & (out_q < CW'(RESP_DEPTH));
  assign accept     = req_valid & req_ready;
  assign resp_valid = (cnt_q != '0);
  assign pop        = resp_valid & resp_ready;
  assign push       = vld_pipe_q[LATENCY-1];

  assign head      = fifo_q[rd_ptr_q];
  assign resp_data = resp_valid ? head.data : '0;
  assign resp_err  = resp_valid & head.err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    pipe_q[0] <= rd_resp;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    if (push) fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
  end

  // Outstanding counts pipeline plus FIFO, so the FIFO can never overflow.
  always_comb begin
    vld_pipe_d = (vld_pipe_q << 1) | LATENCY'(accept);
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    out_d      = out_q + CW'(accept) - CW'(pop);
    if (flush) begin
      vld_pipe_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      out_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios then random traffic, all checked
// against a request-timestamp queue model of the fetch path.
module tb_imem_responder;
  localparam int LAT   = 2;
  localparam int RD    = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        flush, load_en;
  logic [31:0] load_addr, load_data;

  imem_responder #(.N_BITS(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .RESP_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          t;
  } ent_t;

  logic [31:0] mem_m [DEPTH];
  ent_t        q [$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A request accepted at edge e is visible right after edge e+LAT.
  function automatic ent_t model_resp(input logic [31:0] a, input int e);
    ent_t r;
    r.err  = (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
    r.data = r.err ? 32'h0000_0013 : mem_m[a[11:2]];
    r.t    = e + LAT;
    return r;
  endfunction

  task automatic cycle(input logic rv, input logic [31:0] ra, input logic rr,
                       input logic fl, input logic le, input logic [31:0] la,
                       input logic [31:0] ld);
    logic exp_ready, exp_valid, acc, pp;
    req_valid = rv; req_addr = ra; resp_ready = rr; flush = fl;
    load_en = le; load_addr = la; load_data = ld;
    #1;
    exp_ready = rst_n && !fl && (q.size() < RD);
    exp_valid = (q.size() > 0) && (q[0].t <= cyc);
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("resp_data", resp_data, q[0].data);
      chk("resp_err", {31'b0, resp_err}, {31'b0, q[0].err});
    end
    acc = rv && exp_ready;
    pp  = exp_valid && rr;
    @(posedge clk);
    cyc++;
    if (!rst_n || fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(model_resp(ra, cyc));
    end
    if (le && (la[31:2] < DEPTH)) mem_m[la[11:2]] = ld;
    @(negedge clk);
  endtask

  task automatic idle(input logic rr, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic req(input logic [31:0] a, input logic rr);
    cycle(1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, la;
    int r;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;

    // Reset state
    @(negedge clk);
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_data", resp_data, 32'h0);
    chk("rst_err", {31'b0, resp_err}, 32'h0);
    rst_n = 1'b1;

    // Program load
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, i * 4, $urandom);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0050_0093);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h7, 32'h0010_8113);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'hBAD0_BAD0);

    // Back-to-back fetch of words 0 and 1
    req(32'h0, 1'b1);
    req(32'h4, 1'b1);
    idle(1'b1, 4);

    // Misaligned and out-of-range
    req(32'h2, 1'b1);
    req(32'h0000_1000, 1'b1);
    idle(1'b1, 4);

    // Backpressure: only RD accepts, data held, then drain
    for (int i = 0; i < 6; i++) req(32'h8 + i * 4, 1'b0);
    idle(1'b1, 4);

    // Simultaneous accept and handshake
    req(32'h8, 1'b0);
    idle(1'b0, 2);
    req(32'hC, 1'b1);
    req(32'h10, 1'b0);
    req(32'h14, 1'b0);
    idle(1'b1, 5);

    // Flush with two outstanding, load during flush still lands
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    cycle(1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    idle(1'b1, 4);
    req(32'h40, 1'b1);
    idle(1'b1, 3);

    // Asynchronous reset pulse with two outstanding
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    idle(1'b0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, resp_valid}, 32'h0);
    chk("arst_ready", {31'b0, req_ready}, 32'h0);
    chk("arst_data", resp_data, 32'h0);
    chk("arst_err", {31'b0, resp_err}, 32'h0);
    #1 rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    cyc++;
    req(32'h0, 1'b1);
    req(32'h4, 1'b1);
    idle(1'b1, 4);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
      else if (r == 1) a = (DEPTH + $urandom_range(0, 200)) << 2;
      else             a = $urandom_range(0, DEPTH - 1) << 2;
      la = ($urandom_range(0, DEPTH + 75) << 2) | $urandom_range(0, 3);
      cycle(($urandom % 4) != 0, a, ($urandom % 3) != 0, ($urandom % 40) == 0,
            ($urandom % 6) == 0, la, $urandom);
    end
    idle(1'b1, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
